// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per clock, LSB first,
// using a single 1-bit full-adder cell plus a carry flop. A start pulse in IDLE
// captures the operands. The result and carry-out are registered and held until
// the next completion. done is asserted for one cycle when a new result lands.
//
// Handshake: start is a request that is sampled only in IDLE. A start seen in
// any other state is dropped, not queued. The result sum/cout is valid on the
// cycle done is high and stays stable until the next done. busy is high from
// the accepting edge until the end of the done cycle.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;

  // Shared 1-bit full adder fed from the operand LSBs and the carry flop
  always_comb begin
    fa_sum  = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_cout = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  // Next-state and datapath sequencing for IDLE -> RUN -> DONE
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          count_d = '0;
          psum_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        psum_d  = {fa_sum, psum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (count_q == LAST) begin
          // The last bit goes straight into the result. The counter holds so
          // that it never wraps inside an operation.
          sum_d   = {fa_sum, psum_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // All state and registered outputs; asynchronous reset abandons any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for directed and random ops,
// and a 4-bit instance swept over every (a, b, cin) combination.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(st8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // driver: one 8-bit op, observes 20 cycles after the accepting edge.
  // poke > 0 pulses a second start (a=8'h11) sampled at edge poke after capture.
  task automatic drive_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input int poke, output int lat, output int busy_cyc,
                           output int done_cnt, output logic held_ok,
                           output logic [7:0] s_done, output logic c_done);
    logic [8:0] prev;
    prev    = {cout8, sum8};
    held_ok = 1'b1;
    s_done  = 8'h00;
    c_done  = 1'b0;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
    lat      = 0;
    busy_cyc = busy8 ? 1 : 0;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (poke > 0 && i == poke) begin
        start8 = 1'b1;
        a8     = 8'h11;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (busy8) busy_cyc++;
      if (done8) begin
        done_cnt++;
        if (lat == 0) begin
          lat    = i;
          s_done = sum8;
          c_done = cout8;
        end
      end else if (done_cnt == 0 && {cout8, sum8} !== prev) begin
        held_ok = 1'b0;
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    tests_run++;
    if ({busy4, done4, cout4, sum4} !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset4: got busy=%b done=%b cout=%b sum=%h, want all 0", busy4, done4, cout4, sum4);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({busy8, done8, cout8, sum8} !== 11'h000) begin
        tests_failed++;
        $display("FAIL idle_hold cyc %0d: got busy=%b done=%b cout=%b sum=%h, want all 0",
                 i, busy8, done8, cout8, sum8);
      end
    end
  endtask

  task automatic test_carry_ripple();
    int lat, bc, dc;
    logic ho, c;
    logic [7:0] s;
    drive_op8(8'hFF, 8'h01, 1'b0, 0, lat, bc, dc, ho, s, c);
    tests_run++;
    if (lat != 8 || dc != 1) begin
      tests_failed++;
      $display("FAIL ripple_timing: got latency=%0d dones=%0d, want 8 and 1", lat, dc);
    end
    tests_run++;
    if (bc != 9) begin
      tests_failed++;
      $display("FAIL ripple_busy: got busy cycles=%0d, want 9", bc);
    end
    tests_run++;
    if ({c, s} !== 9'h100) begin
      tests_failed++;
      $display("FAIL ripple_result: got cout=%b sum=%h, want cout=1 sum=00", c, s);
    end
  endtask

  task automatic test_carry_in();
    int lat, bc, dc;
    logic ho, c;
    logic [7:0] s;
    drive_op8(8'hA5, 8'h5A, 1'b1, 0, lat, bc, dc, ho, s, c);
    tests_run++;
    if ({c, s} !== 9'h100 || dc != 1) begin
      tests_failed++;
      $display("FAIL carry_in_1: got cout=%b sum=%h dones=%0d, want cout=1 sum=00 dones=1", c, s, dc);
    end
    drive_op8(8'h3C, 8'h42, 1'b0, 0, lat, bc, dc, ho, s, c);
    tests_run++;
    if ({c, s} !== 9'h07E || dc != 1) begin
      tests_failed++;
      $display("FAIL carry_in_2: got cout=%b sum=%h dones=%0d, want cout=0 sum=7e dones=1", c, s, dc);
    end
    tests_run++;
    if (ho !== 1'b1) begin
      tests_failed++;
      $display("FAIL result_hold: got held=%b, want previous result held until done", ho);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, dc;
    logic ho, c;
    logic [7:0] s;
    drive_op8(8'h21, 8'h14, 1'b0, 3, lat, bc, dc, ho, s, c);
    tests_run++;
    if (dc != 1 || lat != 8) begin
      tests_failed++;
      $display("FAIL busy_start_done: got dones=%0d latency=%0d, want 1 and 8", dc, lat);
    end
    tests_run++;
    if ({c, s} !== 9'h035) begin
      tests_failed++;
      $display("FAIL busy_start_result: got cout=%b sum=%h, want cout=0 sum=35", c, s);
    end
    tests_run++;
    if (bc != 9) begin
      tests_failed++;
      $display("FAIL busy_start_busy: got busy cycles=%0d, want 9", bc);
    end
  endtask

  task automatic test_random8();
    int lat, bc, dc;
    logic ho, c;
    logic [7:0] s, av, bv;
    logic cv;
    logic [8:0] expv;
    for (int n = 0; n < 16; n++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      cv = 1'($urandom_range(0, 1));
      expv = {1'b0, av} + {1'b0, bv} + 9'(cv);
      drive_op8(av, bv, cv, 0, lat, bc, dc, ho, s, c);
      tests_run++;
      if ({c, s} !== expv || dc != 1 || lat != 8) begin
        tests_failed++;
        $display("FAIL random8 %h+%h+%b: got {cout,sum}=%h dones=%0d lat=%0d, want %h 1 8",
                 av, bv, cv, {c, s}, dc, lat, expv);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, dc, seen;
    logic ho, c;
    logic [7:0] s, av, bv;
    logic [8:0] expv;
    a8 = 8'h7F; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: got %0d cycles with busy/done, want 0", seen);
    end
    av = 8'($urandom); bv = 8'($urandom);
    expv = {1'b0, av} + {1'b0, bv};
    drive_op8(av, bv, 1'b0, 0, lat, bc, dc, ho, s, c);
    tests_run++;
    if ({c, s} !== expv || dc != 1) begin
      tests_failed++;
      $display("FAIL reset_mid_after: got {cout,sum}=%h dones=%0d, want %h 1", {c, s}, dc, expv);
    end
  endtask

  task automatic test_back_to_back4();
    logic [4:0] exp_q[$];
    logic [4:0] expv;
    logic prev_busy;
    int idx, dones, last_done, cyc;
    idx = 0; dones = 0; last_done = -1; cyc = 0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; start4 = 1'b1;
    prev_busy = busy4;
    while (cyc < 512 * 6 + 100 && dones < 512) begin
      @(posedge clk); #1;
      cyc++;
      if (busy4 && !prev_busy && idx < 512) begin
        exp_q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        idx++;
        if (idx == 512) begin
          start4 = 1'b0;
        end else begin
          a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8];
        end
      end
      if (done4) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sweep4_extra_done: got done at cycle %0d, want none pending", cyc);
        end else begin
          expv = exp_q.pop_front();
          if ({cout4, sum4} !== expv) begin
            tests_failed++;
            $display("FAIL sweep4_result #%0d: got {cout,sum}=%h, want %h", dones, {cout4, sum4}, expv);
          end
        end
        if (last_done >= 0) begin
          tests_run++;
          if (cyc - last_done != 6) begin
            tests_failed++;
            $display("FAIL sweep4_spacing #%0d: got %0d cycles, want 6", dones, cyc - last_done);
          end
        end
        last_done = cyc;
        dones++;
      end
      prev_busy = busy4;
    end
    start4 = 1'b0;
    tests_run++;
    if (dones != 512) begin
      tests_failed++;
      $display("FAIL sweep4_count: got %0d dones, want 512", dones);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_start_while_busy();
    test_random8();
    test_reset_mid_run();
    test_back_to_back4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
